// File: rtl/conv_sequencer.sv
// conv_sequencer: steps a 3x3 kernel over the stored matrix and writes one MAC per output.
// Optional CONV_SAT_EN: 68-bit accumulator with the result clamped to signed 32 bits.
module conv_sequencer #(
    parameter int MAX_DIM = 5,
    parameter int ADDR_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_run,
    input  logic [2:0]          rows,
    input  logic [2:0]          cols,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic signed [31:0]  mem_rd_data,
    output logic [3:0]          kernel_rd_idx,
    input  logic signed [31:0]  kernel_rd_data,
    output logic                out_we,
    output logic [ADDR_W-1:0]   out_addr,
    output logic signed [31:0]  out_data,
    output logic                busy,
    output logic                bonus_done,
    output logic                err
);
`ifdef CONV_SAT_EN
    localparam int ACC_W = 68;
`else
    localparam int ACC_W = 32;
`endif

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

    state_t                   state_q;
    logic [2:0]               rows_q, cols_q, orow_q, ocol_q;
    logic [3:0]               k_q;
    logic signed [31:0]       kern_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [ADDR_W-1:0]        mem_addr_q, out_addr_q;
    logic [3:0]               kidx_q;
    logic signed [31:0]       out_data_q;
    logic                     out_we_q, busy_q, done_q, err_q;

    logic signed [ACC_W-1:0]  prod_w, sum_d;
    logic signed [31:0]       res_d;
    logic                     dims_ok, last_pos;
    logic [2:0]               orow_d, ocol_d;

    function automatic logic [ADDR_W-1:0] tap_addr(
        input logic [2:0] r,
        input logic [2:0] c,
        input logic [3:0] k,
        input logic [2:0] nc
    );
        logic [ADDR_W-1:0] i, j;
        i = (k >= 4'd6) ? ADDR_W'(2) : (k >= 4'd3) ? ADDR_W'(1) : ADDR_W'(0);
        j = ADDR_W'(k) - ADDR_W'(3) * i;
        return (ADDR_W'(r) + i) * ADDR_W'(nc) + ADDR_W'(c) + j;
    endfunction

`ifdef CONV_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(64'sh7FFF_FFFF);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(64'sh8000_0000);
    logic signed [63:0] prod_full;

    assign prod_full = 64'(mem_rd_data) * 64'(kern_q);
    assign prod_w    = ACC_W'(prod_full);

    always_comb begin
        res_d = sum_d[31:0];
        if (sum_d > SAT_MAX)
            res_d = 32'h7FFF_FFFF;
        else if (sum_d < SAT_MIN)
            res_d = 32'h8000_0000;
    end
`else
    assign prod_w = mem_rd_data * kern_q;
    assign res_d  = sum_d;
`endif

    // Tap 0's product lands while the FSM is issuing tap 1.
    assign sum_d = (state_q == ISSUE && k_q == 4'd1) ? prod_w : acc_q + prod_w;

    assign dims_ok = rows >= 3'd3 && 32'(rows) <= MAX_DIM &&
                     cols >= 3'd3 && 32'(cols) <= MAX_DIM;
    assign last_pos = orow_q == rows_q - 3'd3 && ocol_q == cols_q - 3'd3;

    always_comb begin
        orow_d = orow_q;
        ocol_d = ocol_q + 3'd1;
        if (ocol_q == cols_q - 3'd3) begin
            ocol_d = 3'd0;
            orow_d = orow_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            orow_q     <= '0;
            ocol_q     <= '0;
            k_q        <= '0;
            kern_q     <= '0;
            acc_q      <= '0;
            mem_addr_q <= '0;
            kidx_q     <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_run) begin
                        rows_q <= rows;
                        cols_q <= cols;
                        if (dims_ok) begin
                            orow_q     <= '0;
                            ocol_q     <= '0;
                            k_q        <= '0;
                            err_q      <= 1'b0;
                            busy_q     <= 1'b1;
                            mem_addr_q <= '0;
                            kidx_q     <= '0;
                            state_q    <= ISSUE;
                        end else begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    kern_q <= kernel_rd_data;
                    if (k_q != 4'd0)
                        acc_q <= sum_d;
                    if (!start_run) begin
                        busy_q     <= 1'b0;
                        mem_addr_q <= '0;
                        kidx_q     <= '0;
                        state_q    <= IDLE;
                    end else if (k_q == 4'd8) begin
                        mem_addr_q <= '0;
                        kidx_q     <= '0;
                        state_q    <= DRAIN;
                    end else begin
                        k_q        <= k_q + 4'd1;
                        kidx_q     <= k_q + 4'd1;
                        mem_addr_q <= tap_addr(orow_q, ocol_q, k_q + 4'd1, cols_q);
                    end
                end
                DRAIN: begin
                    acc_q <= sum_d;
                    if (!start_run) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        out_we_q   <= 1'b1;
                        out_addr_q <= ADDR_W'(orow_q) * ADDR_W'(cols_q - 3'd2)
                                      + ADDR_W'(ocol_q);
                        out_data_q <= res_d;
                        state_q    <= WRITE;
                    end
                end
                WRITE: begin
                    out_we_q <= 1'b0;
                    if (!start_run) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (last_pos) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        orow_q     <= orow_d;
                        ocol_q     <= ocol_d;
                        k_q        <= '0;
                        kidx_q     <= '0;
                        mem_addr_q <= tap_addr(orow_d, ocol_d, 4'd0, cols_q);
                        state_q    <= ISSUE;
                    end
                end
                DONE: begin
                    if (!start_run) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr      = mem_addr_q;
    assign kernel_rd_idx = kidx_q;
    assign out_we        = out_we_q;
    assign out_addr      = out_addr_q;
    assign out_data      = out_data_q;
    assign busy          = busy_q;
    assign bonus_done    = done_q;
    assign err           = err_q;
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed runs with a write scoreboard for conv_sequencer.
module tb_conv_sequencer;
    localparam int MAX_DIM = 5;
    localparam int ADDR_W  = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_run;
    logic [2:0]          rows, cols;
    logic [ADDR_W-1:0]   mem_addr;
    logic signed [31:0]  mem_rd_data;
    logic [3:0]          kernel_rd_idx;
    logic signed [31:0]  kernel_rd_data;
    logic                out_we;
    logic [ADDR_W-1:0]   out_addr;
    logic signed [31:0]  out_data;
    logic                busy, bonus_done, err;

    logic signed [31:0]  mem [0:31];
    logic signed [31:0]  kern [0:15];

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } exp_t;

    exp_t sb[$];
    int   we_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_we = 1'b0;

    conv_sequencer #(.MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start_run(start_run),
        .rows(rows), .cols(cols),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .kernel_rd_idx(kernel_rd_idx), .kernel_rd_data(kernel_rd_data),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .bonus_done(bonus_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mem_rd_data <= mem[mem_addr];
    assign kernel_rd_data = kern[kernel_rd_idx];

    always @(negedge clk) begin
        exp_t e;
        if (out_we === 1'b1) begin
            checks++;
            assert (prev_we === 1'b0) else begin
                errors++;
                $error("FAIL we_consecutive obs=1 exp=0");
            end
            we_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL sb_unexpected addr=%0d data=%0h exp=none", out_addr, out_data);
            end else begin
                e = sb.pop_front();
                assert (out_addr === e.a && out_data === e.d) else begin
                    errors++;
                    $error("FAIL sb_write obs=%0d/%0h exp=%0d/%0h",
                           out_addr, out_data, e.a, e.d);
                end
            end
        end
        prev_we = out_we;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (bonus_done !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    task automatic load(input logic signed [31:0] mv, input logic signed [31:0] kv);
        for (int a = 0; a < 32; a++) mem[a] = mv;
        for (int t = 0; t < 16; t++) kern[t] = kv;
    endtask

    task automatic run_ones(input string tag);
        int n, c0, base;
        load(32'sd1, 32'sd1);
        sb.push_back('{a: '0, d: 32'd9});
        base = we_cyc.size();
        rows = 3'd3;
        cols = 3'd3;
        start_run = 1'b1;
        c0 = cyc;
        wait_done(40, n);
        chk({tag, "_done_lat"}, 32'(n), 32'd12);
        chk({tag, "_nwrites"}, 32'(we_cyc.size() - base), 32'd1);
        if (we_cyc.size() > base)
            chk({tag, "_we_cycle"}, 32'(we_cyc[base] - c0), 32'd11);
        tick(3);
        chk({tag, "_done_held"}, 32'(bonus_done), 32'd1);
        start_run = 1'b0;
        tick(1);
        chk({tag, "_done_drop"}, 32'(bonus_done), 32'd0);
    endtask

    initial begin
        int n, c0, base;
        logic [31:0] sat_exp;
        rst = 1'b1;
        start_run = 1'b0;
        rows = 3'd0;
        cols = 3'd0;
        load(32'sd0, 32'sd0);
        tick(2);
        chk("rst_outs", {out_we, busy, bonus_done, err, kernel_rd_idx, 3'b0, mem_addr},
            32'd0);
        chk("rst_data", out_data, 32'd0);
        rst = 1'b0;
        tick(2);

        run_ones("t1");

        for (int a = 0; a < 32; a++) mem[a] = 32'(a);
        for (int t = 0; t < 16; t++) kern[t] = (t == 4) ? 32'sd1 : 32'sd0;
        sb.push_back('{a: 5'd0, d: 32'd6});
        sb.push_back('{a: 5'd1, d: 32'd7});
        sb.push_back('{a: 5'd2, d: 32'd8});
        sb.push_back('{a: 5'd3, d: 32'd11});
        sb.push_back('{a: 5'd4, d: 32'd12});
        sb.push_back('{a: 5'd5, d: 32'd13});
        base = we_cyc.size();
        rows = 3'd4;
        cols = 3'd5;
        start_run = 1'b1;
        c0 = cyc;
        tick(2);
        chk("t2_busy", 32'(busy), 32'd1);
        rows = 3'd2;
        tick(7);
        chk("t2_addr_k8", 32'(mem_addr), 32'd12);
        chk("t2_kidx_k8", 32'(kernel_rd_idx), 32'd8);
        wait_done(200, n);
        chk("t2_done_lat", 32'(n + 9), 32'd67);
        chk("t2_nwrites", 32'(we_cyc.size() - base), 32'd6);
        if (we_cyc.size() == base + 6) begin
            chk("t2_first_we", 32'(we_cyc[base] - c0), 32'd11);
            for (int w = 1; w < 6; w++)
                chk("t2_gap", 32'(we_cyc[base+w] - we_cyc[base+w-1]), 32'd11);
        end
        start_run = 1'b0;
        tick(2);

        base = we_cyc.size();
        rows = 3'd2;
        cols = 3'd4;
        start_run = 1'b1;
        tick(1);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_done", 32'(bonus_done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        start_run = 1'b0;
        tick(2);
        chk("t3_err_hold", 32'(err), 32'd1);
        chk("t3_nwrites", 32'(we_cyc.size() - base), 32'd0);

        load(32'sd3, 32'sd1);
        base = we_cyc.size();
        rows = 3'd5;
        cols = 3'd5;
        start_run = 1'b1;
        tick(5);
        chk("t4_err_clr", 32'(err), 32'd0);
        start_run = 1'b0;
        tick(1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_addr_idle", 32'(mem_addr), 32'd0);
        tick(20);
        chk("t4_done", 32'(bonus_done), 32'd0);
        chk("t4_nwrites", 32'(we_cyc.size() - base), 32'd0);

`ifdef CONV_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'hFFFF_FFEE;
`endif
        load(32'sh7FFF_FFFF, 32'sd2);
        sb.push_back('{a: '0, d: sat_exp});
        rows = 3'd3;
        cols = 3'd3;
        start_run = 1'b1;
        wait_done(40, n);
        chk("t5_done_lat", 32'(n), 32'd12);
        start_run = 1'b0;
        tick(2);

        load(32'sd1, 32'sd1);
        base = we_cyc.size();
        rows = 3'd3;
        cols = 3'd3;
        start_run = 1'b1;
        tick(4);
        chk("t6_addr_k3", 32'(mem_addr), 32'd3);
        chk("t6_kidx_k3", 32'(kernel_rd_idx), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_outs", {out_we, busy, bonus_done, err, kernel_rd_idx, 3'b0, mem_addr},
            32'd0);
        chk("t6_rst_data", out_data, 32'd0);
        start_run = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("t6_nwrites", 32'(we_cyc.size() - base), 32'd0);
        run_ones("t6r");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_sequencer.md
# conv_sequencer

Sequences the 3x3 bonus convolution over the stored input matrix. It walks every valid output position, reads each input element and kernel tap in step, multiply-accumulates the products, and writes one result per output position. It sits between the bonus controller and the matrix/kernel storage: it is launched by `start_run`, reports back on `bonus_done`, and owns the read ports of matrix memory and the kernel register file for the duration of a run.

## Interface
- `MAX_DIM`, 5, maximum matrix rows/cols accepted.
- `ADDR_W`, 5, matrix/result address width (must be at least clog2(MAX_DIM*MAX_DIM)).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start_run` input 1: level request from bonus controller; held high for the whole run.
- `rows`, `cols` input 3 each: input matrix dimensions, sampled when a run starts.
- `mem_addr` output ADDR_W: matrix read address; `mem_rd_data` (input 32, signed) returns exactly 1 cycle later.
- `kernel_rd_idx` output 4: tap index 0..8; `kernel_rd_data` (input 32, signed) is combinational from `kernel_rd_idx`.
- `out_we` output 1: one-cycle write strobe.
- `out_addr` output ADDR_W: result address.
- `out_data` output 32 signed: result value.
- `busy` output 1: run in progress.
- `bonus_done` output 1: run finished, level.
- `err` output 1: last run was rejected for bad dimensions.

## Operation
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE: when `start_run`=1, latch `rows`/`cols`.
  - Dimensions valid (both in 3..MAX_DIM): clear the output position (orow=ocol=0), set tap k=0, clear `err`, go to ISSUE.
  - Otherwise: set `err`=1 and go directly to DONE; no memory reads or writes occur.
- ISSUE (9 cycles, k=0..8): i=k/3, j=k%3.
  - `mem_addr`=(orow+i)*cols+(ocol+j), `kernel_rd_idx`=k.
  - Kernel value is registered so it arrives alongside `mem_rd_data`.
  - After k=8, go to DRAIN.
- Accumulate: in the cycle after each issue, acc <= product if the tap being accumulated is 0, else acc + product.
  - Product = signed 32x32. This spans the ISSUE cycles for k=1..8 plus DRAIN.
- DRAIN (1 cycle): accumulates the last tap, then go to WRITE.
- WRITE (1 cycle): `out_we`=1, `out_addr`=orow*(cols-2)+ocol (row-major), `out_data`=acc result.
  - Advance ocol; wrap it to 0 and increment orow at cols-3.
  - If this was the last position (orow=rows-3, ocol=cols-3), go to DONE; else return to ISSUE with k=0.
- DONE: `bonus_done`=1 and held while `start_run`=1. When `start_run`=0, return to IDLE next cycle and drop `bonus_done`. A new run requires `start_run` to go low first.
- Abort: `start_run`=0 in ISSUE/DRAIN/WRITE returns to IDLE next cycle.
  - No further `out_we` is issued; the abort-cycle WRITE still completes if already in WRITE.
  - `bonus_done` is not asserted.
- `busy`=1 in ISSUE, DRAIN and WRITE.
- `err` holds until the next run starts.
- Output values outside WRITE:
  - `mem_addr` and `kernel_rd_idx` are 0 in IDLE/DONE.
  - `out_addr` and `out_data` hold their last values.

## Timing
- Reset values: `out_we`=0, `out_addr`=0, `out_data`=0, `mem_addr`=0, `kernel_rd_idx`=0, `busy`=0, `bonus_done`=0, `err`=0, state IDLE, acc=0.
- Reset mid-run aborts immediately, with no write.
- Per output position: 11 cycles (9 ISSUE, 1 DRAIN, 1 WRITE).
- Start to DONE, valid dimensions: 1 + 11*(rows-2)*(cols-2) cycles counted from the cycle `start_run` is sampled high. `bonus_done` is high the cycle after the final WRITE.
- Bad dimensions: `bonus_done` and `err` are high 1 cycle after sampling.
- `out_we` is never high in two consecutive cycles.
- `rows`/`cols` changes during a run are ignored.

## Configuration
- `CONV_SAT_EN` defined:
  - acc is 68-bit signed and never wraps.
  - In WRITE, `out_data` is acc clamped to [0x80000000, 0x7FFFFFFF].
- `CONV_SAT_EN` undefined:
  - acc is 32-bit; products are truncated to their low 32 bits and sums wrap modulo 2^32.
  - `out_data` is acc.

## Test plan
- 3x3 matrix of all 1, kernel all 1, `start_run` held -> exactly one `out_we` with addr 0 and data 9; `bonus_done` 12 cycles after start; held until `start_run` falls, then IDLE.
- 4x5 matrix mem[a]=a, kernel tap4=1 and all others 0 -> 6 writes: addr 0..5, data 6,7,8,11,12,13; each write 11 cycles apart.
- `rows`=2, `cols`=4 -> `err`=1 and `bonus_done`=1 one cycle later; zero writes.
- 5x5 run, `start_run` dropped at cycle 5 -> no `out_we` ever; `busy`=0 the next cycle; `bonus_done` stays 0.
- 3x3 matrix all 0x7FFFFFFF, kernel all 2 -> `out_data`=0xFFFFFFEE without `CONV_SAT_EN`; `out_data`=0x7FFFFFFF with it.
- Async `rst` pulse mid-ISSUE -> all outputs at reset values the same cycle; a fresh `start_run` afterwards behaves as in the first scenario.
